// File: rtl/hex_view_pkg.sv
// ----------------------------------------------------------------------------
// hex_view_pkg
// Shared definitions for the hex_view_scan channel viewer:
//   - mode_e      : operating mode encodings as driven on the MODE pins
//   - SEG7        : active-low 7-segment codes {g..a} for hex digits 0..F
//                   (bit 7 of every entry is the DP position, left dark)
//   - SEG_BLANK   : all segments and DP dark
// ----------------------------------------------------------------------------
package hex_view_pkg;

    typedef enum logic [1:0] {
        MODE_MAN     = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_FRZ     = 2'd2,
        MODE_MAN_ALT = 2'd3   // behaves exactly like MODE_MAN
    } mode_e;

    // Entry n is the pattern for hex digit n; packed so SEG7[d] selects digit d.
    localparam logic [15:0][7:0] SEG7 = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/hex_seg7_dec.sv
// ----------------------------------------------------------------------------
// hex_seg7_dec
// Combinational hex digit to active-low 7-segment decoder with DP control.
// Ports:
//   digit_i  [3:0]  hex digit to show
//   blank_i         1 = drive every segment and the DP dark
//   dp_on_i         1 = light the decimal point (bit 7 driven low)
//   seg_o    [7:0]  active-low segments, bit 7 = DP, bits 6..0 = g..a
// ----------------------------------------------------------------------------
module hex_seg7_dec
    import hex_view_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    input  logic       dp_on_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            seg_o = {~dp_on_i, SEG7[digit_i][6:0]};
        end
    end

endmodule

// File: rtl/hex_view_scan.sv
// ----------------------------------------------------------------------------
// hex_view_scan
// Selects one of NCH sensor channels (DW bits each) for display on the board
// 7-segment digits. Supports manual selection, timed auto-scan and freeze; the
// displayed value is latched at a limited refresh rate so it stays readable.
// Leading zero data digits may be blanked, the digit after the data shows the
// channel index, and the DP of HEX0 lights when the shown channel is stale.
// Ports:
//   CLK               system clock
//   RESET             synchronous, active-high reset
//   MODE     [1:0]    0/3 manual, 1 auto-scan, 2 freeze
//   SEL      [3:0]    manual channel select (clamped to NCH-1)
//   CH_DATA  [NCH*DW] channel k on bits [k*DW +: DW]
//   CH_VALID [NCH]    one-cycle pulse per channel on a new sample
//   HEX      [NHEX*8] HEXn on bits [n*8 +: 8], active-low, bit 7 = DP
//   LED_CH   [NCH]    one-hot active channel
//   STALE             active channel has had no sample for STALE_TICKS cycles
// ----------------------------------------------------------------------------
module hex_view_scan
    import hex_view_pkg::*;
#(
    parameter int unsigned NCH           = 12,
    parameter int unsigned DW            = 16,
    parameter int unsigned NHEX          = 8,
    parameter int unsigned SCAN_TICKS    = 100000000,
    parameter int unsigned REFRESH_TICKS = 12500000,
    parameter int unsigned STALE_TICKS   = 50000000,
    parameter bit          LZB           = 1'b1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [1:0]          MODE,
    input  logic [3:0]          SEL,
    input  logic [NCH*DW-1:0]   CH_DATA,
    input  logic [NCH-1:0]      CH_VALID,
    output logic [NHEX*8-1:0]   HEX,
    output logic [NCH-1:0]      LED_CH,
    output logic                STALE
);

    localparam int unsigned NDIG = DW / 4;
    localparam int unsigned AW   = $clog2(NCH);
    localparam int unsigned SW   = $clog2(SCAN_TICKS);
    localparam int unsigned RW   = $clog2(REFRESH_TICKS);
    localparam int unsigned GW   = $clog2(STALE_TICKS + 1);

    localparam logic [3:0]    SEL_MAX   = 4'(NCH - 1);
    localparam logic [AW-1:0] ACT_LAST  = AW'(NCH - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_TICKS - 1);
    localparam logic [GW-1:0] AGE_MAX   = GW'(STALE_TICKS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]      act_q,   act_d;
    logic [SW-1:0]      scan_q,  scan_d;
    logic [RW-1:0]      ref_q,   ref_d;
    logic [GW-1:0]      age_q,   age_d;
    logic               lp_q,    lp_d;      // load_pending
    logic [DW-1:0]      disp_q,  disp_d;
    logic [AW-1:0]      dact_q,  dact_d;    // channel index captured with disp_q
    logic [NHEX*8-1:0]  hex_q,   hex_n;
    logic [NCH-1:0]     led_q,   led_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    mode_e              mode;
    logic               frozen;
    logic [3:0]         sel_clamp;
    logic [DW-1:0]      ch_sel;
    logic               vld_act;
    logic               act_chg;
    logic               stale;

    logic [NHEX-1:0][3:0] dig;
    logic [NHEX-1:0]      blk;
    logic [NHEX-1:0]      dp_on;
    logic                 nz;
    logic [NHEX*8-1:0]    hex_d;

    always_comb begin
        mode      = mode_e'(MODE);
        frozen    = (mode == MODE_FRZ);
        sel_clamp = (SEL > SEL_MAX) ? SEL_MAX : SEL;
        stale     = (age_q == AGE_MAX);
    end

    // Channel multiplexer for the active channel's data and valid strobe.
    always_comb begin
        ch_sel  = '0;
        vld_act = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (act_q == AW'(k)) begin
                ch_sel  = CH_DATA[k*DW +: DW];
                vld_act = CH_VALID[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: channel selection, scan prescaler, display latch, age
    // ------------------------------------------------------------------
    always_comb begin
        act_d   = act_q;
        scan_d  = scan_q;
        ref_d   = ref_q;
        age_d   = age_q;
        lp_d    = lp_q;
        disp_d  = disp_q;
        dact_d  = dact_q;
        act_chg = 1'b0;

        case (mode)
            MODE_FRZ: begin
                // everything holds
            end
            MODE_SCAN: begin
                if (scan_q == SCAN_LAST) begin
                    scan_d = '0;
                    act_d  = (act_q == ACT_LAST) ? '0 : act_q + 1'b1;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            default: begin
                scan_d = '0;
                act_d  = AW'(sel_clamp);
            end
        endcase

        if (!frozen) begin
            act_chg = (act_d != act_q);

            // A pending load and a refresh wrap on the same cycle collapse
            // into a single load with the refresh counter restarting at 0.
            if (lp_q || (ref_q == REF_LAST)) begin
                disp_d = ch_sel;
                dact_d = act_q;
                ref_d  = '0;
                lp_d   = 1'b0;
            end else begin
                ref_d  = ref_q + 1'b1;
            end

            if (act_chg) begin
                lp_d = 1'b1;
            end

            if (act_chg || vld_act) begin
                age_d = '0;
            end else if (age_q != AGE_MAX) begin
                age_d = age_q + 1'b1;
            end
        end
    end

    always_comb begin
        led_d = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            led_d[k] = (act_d == AW'(k));
        end
    end

    // ------------------------------------------------------------------
    // Digit map. The index digit uses the channel captured together with
    // the data so the index and the value on the display always agree.
    // ------------------------------------------------------------------
    always_comb begin
        dig   = '0;
        blk   = '1;
        dp_on = '0;
        nz    = 1'b0;
        // Walk from the most significant digit down, tracking whether any
        // digit at or above the current one is non-zero.
        for (int unsigned j = 0; j < NDIG; j++) begin
            nz                 = nz | (|disp_q[(NDIG-1-j)*4 +: 4]);
            dig[NDIG-1-j]      = disp_q[(NDIG-1-j)*4 +: 4];
            blk[NDIG-1-j]      = LZB && ((NDIG-1-j) != 0) && !nz;
        end
        dig[NDIG] = 4'(dact_q);
        blk[NDIG] = 1'b0;
        dp_on[0]  = stale;
    end

    for (genvar n = 0; n < NHEX; n++) begin : g_dec
        hex_seg7_dec u_dec (
            .digit_i (dig[n]),
            .blank_i (blk[n]),
            .dp_on_i (dp_on[n]),
            .seg_o   (hex_d[n*8 +: 8])
        );
    end

    always_comb begin
        hex_n = frozen ? hex_q : hex_d;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            act_q  <= '0;
            scan_q <= '0;
            ref_q  <= '0;
            age_q  <= '0;
            lp_q   <= 1'b1;
            disp_q <= '0;
            dact_q <= '0;
            hex_q  <= '1;
            led_q  <= '0;
        end else begin
            act_q  <= act_d;
            scan_q <= scan_d;
            ref_q  <= ref_d;
            age_q  <= age_d;
            lp_q   <= lp_d;
            disp_q <= disp_d;
            dact_q <= dact_d;
            hex_q  <= hex_n;
            led_q  <= led_d;
        end
    end

    assign HEX    = hex_q;
    assign LED_CH = led_q;
    assign STALE  = stale;

endmodule

// File: tb/tb_hex_view_scan.sv
module tb_hex_view_scan;

    localparam int K_ALL   = 0;
    localparam int K_BYTE  = 1;
    localparam int K_LED   = 2;
    localparam int K_STALE = 3;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  sel;
    logic [63:0] ch_data;
    logic [3:0]  ch_valid;
    logic [63:0] hex;
    logic [3:0]  led;
    logic        stale;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sbq[$];
    int   mon_i;

    hex_view_scan #(
        .NCH           (4),
        .DW            (16),
        .NHEX          (8),
        .SCAN_TICKS    (8),
        .REFRESH_TICKS (4),
        .STALE_TICKS   (16),
        .LZB           (1'b1)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .MODE     (mode),
        .SEL      (sel),
        .CH_DATA  (ch_data),
        .CH_VALID (ch_valid),
        .HEX      (hex),
        .LED_CH   (led),
        .STALE    (stale)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_at(int c, int kind, int idx, logic [63:0] val, string name);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        e.name = name;
        sbq.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic set_ch(int k, logic [15:0] v);
        ch_data[k*16 +: 16] = v;
    endtask

    // Monitor: every cycle, compare all expectations due at this cycle.
    always @(negedge clk) begin
        logic [63:0] act;
        mon_i = 0;
        while (mon_i < sbq.size()) begin
            if (sbq[mon_i].cyc <= cyc) begin
                case (sbq[mon_i].kind)
                    K_ALL:   act = hex;
                    K_BYTE:  act = 64'(hex[sbq[mon_i].idx*8 +: 8]);
                    K_LED:   act = 64'(led);
                    default: act = 64'(stale);
                endcase
                n_checks++;
                if (sbq[mon_i].cyc < cyc) begin
                    $display("FAIL %s missed at cyc %0d (now %0d) expected %h",
                             sbq[mon_i].name, sbq[mon_i].cyc, cyc, sbq[mon_i].val);
                end else if (act !== sbq[mon_i].val) begin
                    $display("FAIL %s @cyc %0d: got %h expected %h",
                             sbq[mon_i].name, cyc, act, sbq[mon_i].val);
                end else begin
                    n_pass++;
                end
                sbq.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        mode     = 2'd0;
        sel      = 4'd0;
        ch_valid = 4'b0000;
        ch_data  = '0;
        set_ch(0, 16'h00C4);
        set_ch(1, 16'h0B07);
        set_ch(2, 16'h1A3F);
        set_ch(3, 16'hF00D);

        // Reset state
        wait_until(2);
        exp_at(2, K_ALL,   0, 64'hFFFFFFFF_FFFFFFFF, "reset_hex");
        exp_at(2, K_LED,   0, 64'h0, "reset_led");
        exp_at(2, K_STALE, 0, 64'h0, "reset_stale");
        rst = 1'b0;

        // Manual select of ch2 = 1A3F, three-cycle latency
        wait_until(4);
        exp_at(4, K_LED, 0, 64'h1, "led_ch0");
        sel = 4'd2;
        exp_at(5, K_LED,  0, 64'h4,  "led_ch2");
        exp_at(6, K_BYTE, 4, 64'hC0, "hex4_before");
        exp_at(6, K_BYTE, 0, 64'h99, "hex0_before");
        exp_at(7, K_ALL,  0, 64'hFFFFFFA4_F988B08E, "hex_ch2_1A3F");

        // Rate-limited latch: loads at edges 10 and 14
        wait_until(7);
        set_ch(2, 16'h0005);
        exp_at(11, K_ALL,  0, 64'hFFFFFFA4_FFFFFF92, "hex_0005_lzb");
        exp_at(12, K_BYTE, 0, 64'h92, "hold_92_a");
        exp_at(13, K_BYTE, 0, 64'h92, "hold_92_b");
        exp_at(14, K_BYTE, 0, 64'h92, "hold_92_c");
        wait_until(11);
        set_ch(2, 16'h0006);
        exp_at(15, K_ALL, 0, 64'hFFFFFFA4_FFFFFF82, "hex_0006_refresh");

        // Select ch3 = F00D (inner zeros not blanked)
        wait_until(15);
        sel = 4'd3;
        exp_at(16, K_LED, 0, 64'h8, "led_ch3");
        exp_at(18, K_ALL, 0, 64'hFFFFFFB0_8EC0C0A1, "hex_ch3_F00D");

        // Auto-scan from ACT=3, SEL ignored
        wait_until(18);
        mode = 2'd1;
        sel  = 4'd1;
        exp_at(25, K_LED,  0, 64'h8,  "scan_hold3");
        exp_at(26, K_LED,  0, 64'h1,  "scan_to0");
        exp_at(27, K_BYTE, 4, 64'hB0, "scan_hex4_lag");
        exp_at(28, K_BYTE, 4, 64'hC0, "scan_hex4_0");
        exp_at(28, K_BYTE, 0, 64'h99, "scan_hex0_ch0");
        exp_at(34, K_LED,  0, 64'h2,  "scan_to1");
        exp_at(35, K_BYTE, 4, 64'hC0, "scan_hex4_lag1");
        exp_at(36, K_BYTE, 4, 64'hF9, "scan_hex4_1");
        exp_at(42, K_LED,  0, 64'h4,  "scan_to2");
        exp_at(44, K_BYTE, 4, 64'hA4, "scan_hex4_2");
        exp_at(50, K_LED,  0, 64'h8,  "scan_to3");
        exp_at(52, K_BYTE, 4, 64'hB0, "scan_hex4_3");
        exp_at(58, K_LED,  0, 64'h1,  "scan_wrap0");
        exp_at(60, K_BYTE, 4, 64'hC0, "scan_hex4_wrap");

        // Freeze at prescaler 5, data changes underneath
        wait_until(63);
        mode = 2'd2;
        exp_at(64, K_ALL, 0, 64'hFFFFFFC0_FFFFC699, "frz_hex_a");
        exp_at(70, K_LED, 0, 64'h1, "frz_led_a");
        exp_at(74, K_ALL, 0, 64'hFFFFFFC0_FFFFC699, "frz_hex_b");
        exp_at(83, K_LED, 0, 64'h1, "frz_led_b");
        exp_at(84, K_ALL, 0, 64'hFFFFFFC0_FFFFC699, "frz_hex_c");
        wait_until(64);
        set_ch(0, 16'h1234);
        wait_until(83);
        mode = 2'd1;
        exp_at(85, K_LED, 0, 64'h1, "resume_hold");
        exp_at(86, K_LED, 0, 64'h2, "resume_adv");
        exp_at(88, K_ALL, 0, 64'hFFFFFFF9_FF83C0F8, "hex_ch1_0B07");

        // Stale detection on ch1
        wait_until(88);
        mode = 2'd0;
        sel  = 4'd1;
        exp_at(101, K_STALE, 0, 64'h0,  "age15_fresh");
        exp_at(102, K_STALE, 0, 64'h1,  "age16_stale");
        exp_at(102, K_BYTE,  0, 64'hF8, "dp_dark");
        exp_at(103, K_BYTE,  0, 64'h78, "dp_lit");
        exp_at(105, K_STALE, 0, 64'h1,  "stale_held");
        wait_until(95);
        ch_valid = 4'b0001;            // other channel: must not clear age
        wait_until(96);
        ch_valid = 4'b0000;
        wait_until(105);
        ch_valid = 4'b0010;
        exp_at(106, K_STALE, 0, 64'h0,  "valid_clears");
        exp_at(106, K_BYTE,  0, 64'h78, "dp_lag");
        exp_at(107, K_BYTE,  0, 64'hF8, "dp_off");
        wait_until(106);
        ch_valid = 4'b0000;
        exp_at(121, K_STALE, 0, 64'h0, "restale_15");
        exp_at(122, K_STALE, 0, 64'h1, "restale_16");
        exp_at(124, K_STALE, 0, 64'h1, "restale_held");
        wait_until(124);
        sel = 4'd3;
        exp_at(125, K_STALE, 0, 64'h0, "sel_clears");

        // Reset in the middle of an auto-scan with ACT=2
        wait_until(125);
        mode = 2'd1;
        sel  = 4'd0;
        exp_at(133, K_LED, 0, 64'h1, "scan2_to0");
        exp_at(141, K_LED, 0, 64'h2, "scan2_to1");
        exp_at(149, K_LED, 0, 64'h4, "scan2_to2");
        exp_at(152, K_LED, 0, 64'h4, "scan2_hold2");
        wait_until(152);
        rst = 1'b1;
        exp_at(153, K_ALL,   0, 64'hFFFFFFFF_FFFFFFFF, "midrst_hex");
        exp_at(153, K_LED,   0, 64'h0, "midrst_led");
        exp_at(153, K_STALE, 0, 64'h0, "midrst_stale");
        wait_until(153);
        rst  = 1'b0;
        mode = 2'd0;
        sel  = 4'd0;
        exp_at(154, K_LED, 0, 64'h1, "post_led_ch0");
        exp_at(155, K_ALL, 0, 64'hFFFFFFC0_F9A4B099, "post_hex_1234");

        wait_until(160);
        while (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL %s never checked (due cyc %0d) expected %h",
                     sbq[0].name, sbq[0].cyc, sbq[0].val);
            sbq.delete(0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
